redux_csa: RTL and testbench

- Parallel M:2 adder reductor: compresses M W-bit operands into two W-bit words whose modulo-2^W sum equals the modulo-2^W sum of all M operands.
- Built as a carry-save tree of 3:2 compressors with no carry-propagate adder inside.
- Sits in front of a single final adder in ALU and multiply/accumulate datapaths.
- Optional output register stage; clock and reset are used only when that stage is enabled.

---
 rtl/redux_csa_pkg.sv | 34 +++
 rtl/redux_csa_csa.sv | 22 ++
 rtl/redux_csa.sv | 94 +++++++++
 tb/tb_redux_csa.sv | 126 ++++++++++++
 4 files changed

// File: rtl/redux_csa_pkg.sv
// redux_csa_pkg: shared constants and elaboration-time helpers for the
// carry-save reduction tree (word counts per level, level count).
package redux_csa_pkg;

   // Words remaining after one 3:2 level: each full triple yields two
   // words, leftovers (1 or 2) pass through.
   function automatic int unsigned next_cnt(input int unsigned n);
      return (n / 3) * 2 + (n % 3);
   endfunction

   // Number of 3:2 levels needed to bring m words down to two (or one).
   function automatic int unsigned num_levels(input int unsigned m);
      int unsigned n;
      int unsigned lv;
      n  = m;
      lv = 0;
      while (n > 2) begin
         n  = next_cnt(n);
         lv = lv + 1;
      end
      return lv;
   endfunction

   // Word count present at the input of level l (l = 0 is the operand list).
   function automatic int unsigned lvl_cnt(input int unsigned m, input int unsigned l);
      int unsigned n;
      n = m;
      for (int unsigned i = 0; i < l; i++) begin
         n = next_cnt(n);
      end
      return n;
   endfunction

endpackage

// File: rtl/redux_csa_csa.sv
// csa_3to2: word-wide 3:2 compressor (full adder per bit, no carry chain).
//   a, b, c : input  W-bit words
//   s       : output W-bit bitwise sum
//   k       : output W-bit carry word, majority shifted left by one, LSB 0,
//             bit shifted past W-1 discarded (a + b + c == s + k mod 2^W)
module csa_3to2 #(
   parameter int unsigned W = 17
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] s,
   output logic [W-1:0] k
);

   logic [W-1:0] maj;

   assign s   = a ^ b ^ c;
   assign maj = (a & b) | (a & c) | (b & c);
   assign k   = maj << 1;

endmodule

// File: rtl/redux_csa.sv
// redux_csa: M:2 carry-save reductor. Compresses M W-bit operands into two
// W-bit words whose modulo-2^W sum equals the sum of all operands.
//   clock : rising-edge clock, used only when OREG = 1
//   reset : synchronous active-high clear of the output register (OREG = 1)
//   x     : M*W packed operands, operand i = x[i*W +: W]
//   q     : 2*W packed result pair, q0 = q[W-1:0], q1 = q[2*W-1:W]
module redux_csa
   import redux_csa_pkg::*;
#(
   parameter int unsigned W    = 17,
   parameter int unsigned M    = 13,
   parameter int unsigned OREG = 0
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [M*W-1:0] x,
   output logic [2*W-1:0] q
);

   localparam int unsigned L = num_levels(M);
   localparam int unsigned F = lvl_cnt(M, L);

   if (W < 1 || M < 1 || OREG > 1) begin : g_param_check
      $error("redux_csa: illegal parameters W=%0d M=%0d OREG=%0d", W, M, OREG);
   end

   // Each level owns its own input/output vectors sized to its word count;
   // level l reads the previous level's output by hierarchical reference.
   for (genvar l = 0; l < L; l++) begin : g_lvl
      localparam int unsigned N  = lvl_cnt(M, l);
      localparam int unsigned NN = next_cnt(N);
      localparam int unsigned T  = N / 3;
      localparam int unsigned R  = N % 3;

      logic [N*W-1:0]  w_in;
      logic [NN*W-1:0] w_out;

      if (l == 0) begin : g_src
         assign w_in = x;
      end else begin : g_src
         assign w_in = g_lvl[l-1].w_out;
      end

      for (genvar t = 0; t < T; t++) begin : g_csa
         csa_3to2 #(.W(W)) u_csa (
            .a (w_in[(3*t)*W   +: W]),
            .b (w_in[(3*t+1)*W +: W]),
            .c (w_in[(3*t+2)*W +: W]),
            .s (w_out[(2*t)*W   +: W]),
            .k (w_out[(2*t+1)*W +: W])
         );
      end

      for (genvar r = 0; r < R; r++) begin : g_pass
         assign w_out[(2*T+r)*W +: W] = w_in[(3*T+r)*W +: W];
      end
   end

   logic [F*W-1:0] fin;
   logic [2*W-1:0] sum;

   if (L == 0) begin : g_fin
      assign fin = x;
   end else begin : g_fin
      assign fin = g_lvl[L-1].w_out;
   end

   if (F == 1) begin : g_pair
      assign sum = {{W{1'b0}}, fin[W-1:0]};
   end else begin : g_pair
      assign sum = fin[2*W-1:0];
   end

   if (OREG != 0) begin : g_oreg
      logic [2*W-1:0] q_d;
      logic [2*W-1:0] q_q;

      always_comb begin
         q_d = sum;
      end

      always_ff @(posedge clock) begin
         if (reset) q_q <= '0;
         else       q_q <= q_d;
      end

      assign q = q_q;
   end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = ^{clock, reset};
      assign q = sum;
   end

endmodule

// File: tb/tb_redux_csa.sv
module tb_redux_csa;

   localparam int unsigned W = 17;
   localparam int unsigned M = 13;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   logic [M*W-1:0] x_c;
   logic [2*W-1:0] q_c;
   logic [M*W-1:0] x_r;
   logic [2*W-1:0] q_r;
   logic [W-1:0]   x_m1;
   logic [2*W-1:0] q_m1;
   logic [2*W-1:0] x_m2;
   logic [2*W-1:0] q_m2;
   logic [11:0]    x_m3;
   logic [7:0]     q_m3;

   redux_csa #(.W(W), .M(M), .OREG(0)) u_comb (
      .clock(clock), .reset(reset), .x(x_c), .q(q_c));
   redux_csa #(.W(W), .M(M), .OREG(1)) u_reg (
      .clock(clock), .reset(reset), .x(x_r), .q(q_r));
   redux_csa #(.W(W), .M(1), .OREG(0)) u_m1 (
      .clock(clock), .reset(reset), .x(x_m1), .q(q_m1));
   redux_csa #(.W(W), .M(2), .OREG(0)) u_m2 (
      .clock(clock), .reset(reset), .x(x_m2), .q(q_m2));
   redux_csa #(.W(4), .M(3), .OREG(0)) u_m3 (
      .clock(clock), .reset(reset), .x(x_m3), .q(q_m3));

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_sum(input logic [M*W-1:0] v);
      logic [W-1:0] acc;
      acc = '0;
      for (int i = 0; i < int'(M); i++) acc = acc + v[i*W +: W];
      return acc;
   endfunction

   function automatic logic [W-1:0] pair_sum(input logic [2*W-1:0] v);
      return v[W-1:0] + v[2*W-1:W];
   endfunction

   task automatic rand_ops(output logic [M*W-1:0] v);
      for (int i = 0; i < int'(M); i++) v[i*W +: W] = W'($urandom);
   endtask

   logic [M*W-1:0] v;
   logic [W-1:0]   p;

   initial begin
      x_c  = '0;
      x_r  = '0;
      x_m1 = 17'h0ABCD;
      x_m2 = {17'd7, 17'd5};
      x_m3 = {4'd15, 4'd15, 4'd15};
      #1;

      // Combinational directed cases
      check("all_zero", 64'(q_c), 64'd0);
      for (int i = 0; i < int'(M); i++) x_c[i*W +: W] = 17'h1FFFF;
      #1 check("all_ones_sum", 64'(pair_sum(q_c)), 64'h1FFF3);
      x_c = '0;
      x_c[5*W +: W] = 17'h00001;
      #1 check("single_x5", 64'(pair_sum(q_c)), 64'd1);
      x_c = '0;
      x_c[12*W +: W] = 17'h10000;
      x_c[0 +: W]    = 17'h10000;
      #1 check("msb_wrap", 64'(pair_sum(q_c)), 64'd0);
      check("m1_pair", 64'(q_m1), {30'd0, 17'd0, 17'h0ABCD});
      check("m2_pair", 64'(q_m2), {30'd0, 17'd7, 17'd5});
      p = 17'(q_m3[3:0] + q_m3[7:4]);
      check("m3_w4_sum", 64'(p[3:0]), 64'd13);

      // Combinational random sweep
      for (int c = 0; c < 200; c++) begin
         @(posedge clock);
         #1;
         rand_ops(v);
         x_c = v;
         #2 check("rand_comb", 64'(pair_sum(q_c)), 64'(ref_sum(v)));
      end

      // Registered instance: reset held for two edges
      reset = 1'b1;
      rand_ops(v);
      x_r = v;
      for (int e = 0; e < 2; e++) begin
         @(posedge clock);
         #1 check("reset_hold", 64'(q_r), 64'd0);
      end
      reset = 1'b0;

      // Streaming, one-cycle latency
      for (int c = 0; c < 20; c++) begin
         rand_ops(v);
         x_r = v;
         @(posedge clock);
         #1 check("reg_stream", 64'(pair_sum(q_r)), 64'(ref_sum(v)));
      end

      // Mid-stream reset discards the in-flight result
      for (int i = 0; i < int'(M); i++) x_r[i*W +: W] = 17'h00003;
      reset = 1'b1;
      @(posedge clock);
      #1 check("reset_mid", 64'(q_r), 64'd0);
      reset = 1'b0;
      @(posedge clock);
      #1 check("after_reset", 64'(pair_sum(q_r)), 64'd39);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
